// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_sp_clr data RAM.
//   state_t     - clear sequencer states
//   bytes_of    - number of byte lanes in a data word
//   idx_w       - array index width for a given depth
//   merge_byte  - byte-lane merge used by partial writes
//   in_range    - address-against-depth check
package ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int unsigned bytes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Keep the stored byte unless its enable is set.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: clear-sweep sequencer for ram_sp_clr.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; starts a full sweep
//   clr      - single-cycle sweep request, honoured only when idle
//   busy     - high for exactly DEPTH cycles while sweeping
//   clr_we   - write strobe for the sweep
//   clr_addr - word address being cleared this cycle
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: parametrised single-port synchronous RAM with byte enables,
// registered read path (optional second stage) and a hardware clear sweep.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; starts a clear sweep
//   ena      - access enable
//   wena     - 1 = write, 0 = read (qualified by ena)
//   be       - byte write enables, bit i covers data_in[8i+7:8i]
//   addr     - word address
//   data_in  - write data
//   clr      - single-cycle clear-sweep request
//   data_out - read data, holds between reads
//   rd_valid - pulse when data_out carries new read data
//   addr_err - pulse for an access with addr >= DEPTH
//   busy     - high while the clear sweep runs; accesses ignored
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int unsigned        DATA_W  = 32,
    parameter int unsigned        ADDR_W  = 5,
    parameter int unsigned        DEPTH   = 32,
    parameter int unsigned        OUT_REG = 0,
    parameter int unsigned        WR_THRU = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wena,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  clr,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  addr_err,
    output logic                  busy
);

    localparam int unsigned BYTES = bytes_of(DATA_W);
    localparam int unsigned IDX_W = idx_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_clr_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  clr_idx;
    logic              in_rng;
    logic              access;
    logic              wr_hit;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    assign idx     = addr[IDX_W-1:0];
    assign clr_idx = clr_addr[IDX_W-1:0];
    assign in_rng  = in_range(32'(addr), DEPTH);
    // A clr request in IDLE takes priority over a same-cycle access.
    assign access  = ena && !busy && !clr;
    assign wr_hit  = access && wena && in_rng;
    assign rd_word = in_rng ? mem[idx] : '0;

    always_comb begin
        merged = rd_word;
        for (int unsigned i = 0; i < BYTES; i++) begin
            merged[8*i +: 8] = merge_byte(rd_word[8*i +: 8], data_in[8*i +: 8], be[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= CLR_VAL;
        end else if (wr_hit) begin
            mem[idx] <= merged;
        end
    end

    // First-stage result of this cycle's access.
    logic              nxt_load;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_valid;
    logic              nxt_err;

    always_comb begin
        nxt_load  = 1'b0;
        nxt_data  = '0;
        nxt_valid = 1'b0;
        nxt_err   = 1'b0;
        if (access) begin
            if (!wena) begin
                // Out-of-range reads return zero (rd_word is zero then).
                nxt_load  = 1'b1;
                nxt_valid = 1'b1;
                nxt_data  = rd_word;
                nxt_err   = !in_rng;
            end else if (!in_rng) begin
                nxt_err = 1'b1;
            end else if (WR_THRU != 0) begin
                nxt_load = 1'b1;
                nxt_data = merged;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out2
            logic              s1_load;
            logic [DATA_W-1:0] s1_data;
            logic              s1_valid;
            logic              s1_err;

            // Anything already in s1 drains normally, so a read issued the
            // cycle before a clr request still completes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_load  <= 1'b0;
                    s1_data  <= '0;
                    s1_valid <= 1'b0;
                    s1_err   <= 1'b0;
                    data_out <= '0;
                    rd_valid <= 1'b0;
                    addr_err <= 1'b0;
                end else begin
                    s1_load  <= nxt_load;
                    s1_data  <= nxt_data;
                    s1_valid <= nxt_valid;
                    s1_err   <= nxt_err;
                    if (s1_load) begin
                        data_out <= s1_data;
                    end
                    rd_valid <= s1_valid;
                    addr_err <= s1_err;
                end
            end
        end else begin : g_out1
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                    addr_err <= 1'b0;
                end else begin
                    if (nxt_load) begin
                        data_out <= nxt_data;
                    end
                    rd_valid <= nxt_valid;
                    addr_err <= nxt_err;
                end
            end
        end
    endgenerate

endmodule
